gpu_decode_stage: RTL and testbench
===================================

Name: gpu_decode_stage

Overview:
- Parametrised instruction decode stage between fetch and issue.
- Splits the instruction word into opcode, register and immediate fields.
- Classifies the opcode into an execution-unit class, flags illegal opcodes, and tracks HALT and illegal-trap state.
- Valid/ready on both sides, with a 2-entry skid buffer for full throughput.

Parameters:
- INSTR_W, 32, instruction word width.
- OPC_W, 8, opcode field width (>=8). Opcode occupies [INSTR_W-1 -: OPC_W]. Opcode values >8'hFF are illegal.
- RA_W, 5, register-address width. Fields rd, rs1, rs2 follow the opcode, in that order, MSB first.
- IMM_W, INSTR_W-OPC_W-3*RA_W, immediate width. Derived; must be >=1.
- ILLEGAL_TRAP, 1. When 1, an illegal opcode stalls the stage until cleared; when 0, the illegal flag is reported only.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch word valid
- in_ready  out  1  stage can accept
- in_instr  in  INSTR_W  instruction word
- out_valid  out  1  decoded entry valid
- out_ready  in  1  issue accepts
- out_opcode  out  OPC_W  opcode field
- out_rd / out_rs1 / out_rs2  out  RA_W each  register fields
- out_imm  out  INSTR_W  immediate, sign-extended from IMM_W
- out_class  out  3  0 INT, 1 FP, 2 MEM, 3 CTRL, 4 SYS, 5 NOP, 7 ILLEGAL
- out_is_imm  out  1  opcode is 0x10-0x12
- out_writes_rd  out  1  INT (excluding NOP), FP, 0xC0 load, 0xF1 CSR read
- flush  in  1  synchronous pipeline flush
- resume  in  1  leave HALTED
- clear_err  in  1  leave ERROR
- halted  out  1  state==HALTED
- error  out  1  state==ERROR
- err_opcode  out  OPC_W  opcode that caused ERROR

Behaviour:
- Reset: all out_*, halted, error, err_opcode = 0; in_ready = 1; state = RUN; both buffers empty.

Legal opcode sets; anything else is ILLEGAL:
- INT: 01-06, 10-12, 20-24, 30-34, 40-49, 60-63, 70-74, 80-81, 90-92.
- NOP: 9F.
- FP: A0-AD, B0-B5.
- MEM: C0-C1.
- CTRL: E0-E5.
- SYS: F0-F2.

Datapath and handshake:
- Decode is combinational on in_instr and registered into the output register. Latency is 1 cycle from accept (in_valid & in_ready) to out_valid.
- Output register plus one skid register. in_ready = !skid_valid && state==RUN, and it is registered.
- If the output register holds data and out_ready=0 while an input is accepted, the input goes to the skid register.
- When out_ready rises, skid data moves to the output register on the next edge.
- Back-to-back accepts sustain 1 instruction/cycle while out_ready=1.
- out_* fields are stable while out_valid & !out_ready. No entry is dropped or duplicated except on flush.

State machine (RUN, HALTED, ERROR):
- RUN -> HALTED: an accepted opcode F0. The HALT itself still propagates to the output.
- RUN -> ERROR: an accepted ILLEGAL opcode with ILLEGAL_TRAP=1. err_opcode captures the opcode; the illegal entry still propagates with class 7.
- HALTED -> RUN on resume. ERROR -> RUN on clear_err, which also clears err_opcode to 0.
- resume in RUN/ERROR and clear_err in RUN/HALTED are ignored.
- ILLEGAL_TRAP=0: illegal opcodes pass with class 7 and the state is unchanged.
- Outside RUN, in_ready=0. Buffered entries still drain to the output normally.

Boundary cases:
- flush: next edge empties both buffers (out_valid=0) and sets state=RUN. halted and error clear; err_opcode clears.
- flush wins over a same-cycle accept or a same-cycle state transition.
- Async reset mid-transfer: everything returns to reset values immediately.

Optional Feature:
- DECODE_PERF_CNT_EN: adds perf_decoded (32-bit, counts accepted instructions) and perf_stall (32-bit, counts cycles with in_valid & !in_ready).
- Both counters wrap at 2^32, reset to 0, and are not cleared by flush.
- Without the macro the ports and counters do not exist.

Test Plan:
- Stream 0x01000000, 0xA0000000, 0xC0000000, 0xE0000000 with out_ready=1 -> classes 0, 1, 2, 3 on consecutive cycles; 1-cycle latency; in_ready stays 1.
- ADD_I word 0x10_000000 | imm 0x1FF (IMM_W=9) -> out_is_imm=1, out_imm=0xFFFFFFFF, out_writes_rd=1.
- out_ready=0 while 3 words are offered -> 2 accepted, in_ready=0 for the third; releasing out_ready delivers all 3 in order with none lost.
- Opcode 0x07 with ILLEGAL_TRAP=1 -> class 7, error=1, err_opcode=0x07, in_ready=0; clear_err -> in_ready=1 next cycle, error=0.
- Opcode 0xF0 -> out_class=4, halted=1, in_ready=0; resume -> RUN. Repeat with flush asserted on the accept cycle -> no output and no halt.
- With DECODE_PERF_CNT_EN: 5 accepts plus 3 stall cycles -> perf_decoded=5, perf_stall=3.

Source files
------------

// File: rtl/gpu_decode_stage.sv
// gpu_decode_stage: instruction decode between fetch and issue.
// Splits the instruction word into fields, classifies the opcode and runs a
// RUN/HALTED/ERROR control FSM. The stage has an output register plus one
// skid register, so it sustains one instruction per cycle.
// Optional: define DECODE_PERF_CNT_EN to add the perf_decoded/perf_stall counters.
module gpu_decode_stage #(
  parameter int INSTR_W      = 32,
  parameter int OPC_W        = 8,
  parameter int RA_W         = 5,
  parameter int IMM_W        = INSTR_W - OPC_W - 3*RA_W,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [RA_W-1:0]    out_rd,
  output logic [RA_W-1:0]    out_rs1,
  output logic [RA_W-1:0]    out_rs2,
  output logic [INSTR_W-1:0] out_imm,
  output logic [2:0]         out_class,
  output logic               out_is_imm,
  output logic               out_writes_rd,
  input  logic               flush,
  input  logic               resume,
  input  logic               clear_err,
  output logic               halted,
  output logic               error,
  output logic [OPC_W-1:0]   err_opcode
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_decoded,
  output logic [31:0]        perf_stall
`endif
);

  localparam logic [2:0] CLS_INT     = 3'd0;
  localparam logic [2:0] CLS_FP      = 3'd1;
  localparam logic [2:0] CLS_MEM     = 3'd2;
  localparam logic [2:0] CLS_CTRL    = 3'd3;
  localparam logic [2:0] CLS_SYS     = 3'd4;
  localparam logic [2:0] CLS_NOP     = 3'd5;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [RA_W-1:0]    rd;
    logic [RA_W-1:0]    rs1;
    logic [RA_W-1:0]    rs2;
    logic [INSTR_W-1:0] imm;
    logic [2:0]         cls;
    logic               is_imm;
    logic               writes_rd;
  } entry_t;

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_ERROR} state_t;

  entry_t           dec;
  entry_t           out_q;
  entry_t           skid_q;
  logic             out_v;
  logic             skid_v;
  logic             out_v_n;
  logic             skid_v_n;
  logic             ld_out_skid;
  logic             ld_out_in;
  logic             ld_skid;
  logic             accept;
  logic [7:0]       opc_lo;
  logic             opc_hi_nz;
  state_t           state;
  state_t           state_n;
  logic [OPC_W-1:0] err_n;

  assign accept = in_valid && in_ready;

  // Combinational field split and opcode classification of the incoming word
  always_comb begin
    dec           = '0;
    dec.opcode    = in_instr[INSTR_W-1 -: OPC_W];
    dec.rd        = in_instr[INSTR_W-OPC_W-1 -: RA_W];
    dec.rs1       = in_instr[INSTR_W-OPC_W-RA_W-1 -: RA_W];
    dec.rs2       = in_instr[INSTR_W-OPC_W-2*RA_W-1 -: RA_W];
    dec.imm       = {{(INSTR_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
    opc_lo        = dec.opcode[7:0];
    opc_hi_nz     = (dec.opcode >> 8) != '0;
    case (opc_lo) inside
      [8'h01:8'h06], [8'h10:8'h12], [8'h20:8'h24], [8'h30:8'h34],
      [8'h40:8'h49], [8'h60:8'h63], [8'h70:8'h74], [8'h80:8'h81],
      [8'h90:8'h92]:                 dec.cls = CLS_INT;
      8'h9F:                         dec.cls = CLS_NOP;
      [8'hA0:8'hAD], [8'hB0:8'hB5]:  dec.cls = CLS_FP;
      [8'hC0:8'hC1]:                 dec.cls = CLS_MEM;
      [8'hE0:8'hE5]:                 dec.cls = CLS_CTRL;
      [8'hF0:8'hF2]:                 dec.cls = CLS_SYS;
      default:                       dec.cls = CLS_ILLEGAL;
    endcase
    if (opc_hi_nz) dec.cls = CLS_ILLEGAL;
    dec.is_imm    = !opc_hi_nz && (opc_lo inside {[8'h10:8'h12]});
    dec.writes_rd = (dec.cls == CLS_INT) || (dec.cls == CLS_FP) ||
                    (!opc_hi_nz && (opc_lo == 8'hC0 || opc_lo == 8'hF1));
  end

  // Control FSM next state: HALT/illegal on accept, resume/clear_err to leave, flush overrides all
  always_comb begin
    state_n = state;
    err_n   = err_opcode;
    if (flush) begin
      state_n = ST_RUN;
      err_n   = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (dec.cls == CLS_ILLEGAL && ILLEGAL_TRAP != 0) begin
              state_n = ST_ERROR;
              err_n   = dec.opcode;
            end else if (dec.opcode == OPC_W'(8'hF0)) begin
              state_n = ST_HALTED;
            end
          end
        end
        ST_HALTED: if (resume) state_n = ST_RUN;
        ST_ERROR: begin
          if (clear_err) begin
            state_n = ST_RUN;
            err_n   = '0;
          end
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

  // Buffer steering: output register refills from skid first, otherwise from the input
  always_comb begin
    out_v_n     = out_v;
    skid_v_n    = skid_v;
    ld_out_skid = 1'b0;
    ld_out_in   = 1'b0;
    ld_skid     = 1'b0;
    if (flush) begin
      out_v_n  = 1'b0;
      skid_v_n = 1'b0;
    end else if (!out_v || out_ready) begin
      if (skid_v) begin
        ld_out_skid = 1'b1;
        out_v_n     = 1'b1;
        skid_v_n    = 1'b0;
      end else begin
        ld_out_in = accept;
        out_v_n   = accept;
      end
    end else if (accept) begin
      ld_skid  = 1'b1;
      skid_v_n = 1'b1;
    end
  end

  // Registers for buffers, FSM state, trap opcode and the registered in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v      <= 1'b0;
      skid_v     <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      state      <= ST_RUN;
      err_opcode <= '0;
      in_ready   <= 1'b1;
    end else begin
      out_v      <= out_v_n;
      skid_v     <= skid_v_n;
      if (ld_out_skid)    out_q <= skid_q;
      else if (ld_out_in) out_q <= dec;
      if (ld_skid)        skid_q <= dec;
      state      <= state_n;
      err_opcode <= err_n;
      in_ready   <= !skid_v_n && (state_n == ST_RUN);
    end
  end

  assign out_valid     = out_v;
  assign out_opcode    = out_q.opcode;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_imm       = out_q.imm;
  assign out_class     = out_q.cls;
  assign out_is_imm    = out_q.is_imm;
  assign out_writes_rd = out_q.writes_rd;
  assign halted        = (state == ST_HALTED);
  assign error         = (state == ST_ERROR);

`ifdef DECODE_PERF_CNT_EN
  // Free-running accept and stall counters; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded <= '0;
      perf_stall   <= '0;
    end else begin
      if (in_valid && in_ready)  perf_decoded <= perf_decoded + 32'd1;
      if (in_valid && !in_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_decode_stage.sv
// Testbench for gpu_decode_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the decode stage.
module tb_gpu_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic [2:0]  out_class;
  logic        out_is_imm;
  logic        out_writes_rd;
  logic        flush;
  logic        resume;
  logic        clear_err;
  logic        halted;
  logic        error;
  logic [7:0]  err_opcode;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded;
  logic [31:0] perf_stall;
`endif

  gpu_decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_imm       (out_imm),
    .out_class     (out_class),
    .out_is_imm    (out_is_imm),
    .out_writes_rd (out_writes_rd),
    .flush         (flush),
    .resume        (resume),
    .clear_err     (clear_err),
    .halted        (halted),
    .error         (error),
    .err_opcode    (err_opcode)
`ifdef DECODE_PERF_CNT_EN
    ,
    .perf_decoded  (perf_decoded),
    .perf_stall    (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  cls;
    logic        is_imm;
    logic        wr_rd;
  } exp_entry_t;

  exp_entry_t  q[$];
  int          m_state;
  logic [7:0]  m_err;
  logic        m_in_ready;
  logic        last_accept;
  int unsigned m_perf_dec;
  int unsigned m_perf_stall;
  int          vectors;
  int          miscompares;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  function automatic bit inRange(input int op, input int lo, input int hi);
    return (op >= lo) && (op <= hi);
  endfunction

  // Reference decode computed straight from the opcode tables with plain arithmetic
  function automatic exp_entry_t expDecode(input logic [31:0] w);
    exp_entry_t e;
    int op;
    int v;
    op    = int'(w >> 24);
    e.opc = 8'(op);
    e.rd  = 5'((w >> 19) & 32'h1F);
    e.rs1 = 5'((w >> 14) & 32'h1F);
    e.rs2 = 5'((w >> 9) & 32'h1F);
    v     = int'(w & 32'h1FF);
    if (v >= 256) v = v - 512;
    e.imm = 32'(v);
    if (inRange(op, 'h01, 'h06) || inRange(op, 'h10, 'h12) || inRange(op, 'h20, 'h24) ||
        inRange(op, 'h30, 'h34) || inRange(op, 'h40, 'h49) || inRange(op, 'h60, 'h63) ||
        inRange(op, 'h70, 'h74) || inRange(op, 'h80, 'h81) || inRange(op, 'h90, 'h92))
      e.cls = 3'd0;
    else if (op == 'h9F) e.cls = 3'd5;
    else if (inRange(op, 'hA0, 'hAD) || inRange(op, 'hB0, 'hB5)) e.cls = 3'd1;
    else if (inRange(op, 'hC0, 'hC1)) e.cls = 3'd2;
    else if (inRange(op, 'hE0, 'hE5)) e.cls = 3'd3;
    else if (inRange(op, 'hF0, 'hF2)) e.cls = 3'd4;
    else e.cls = 3'd7;
    e.is_imm = inRange(op, 'h10, 'h12);
    e.wr_rd  = (e.cls == 3'd0) || (e.cls == 3'd1) || (op == 'hC0) || (op == 'hF1);
    return e;
  endfunction

  // Compare every visible DUT output with the model
  task automatic checkModel();
    checkOutput("out_valid", 64'(out_valid), 64'(q.size() > 0));
    checkOutput("in_ready", 64'(in_ready), 64'(m_in_ready));
    checkOutput("halted", 64'(halted), 64'(m_state == 1));
    checkOutput("error", 64'(error), 64'(m_state == 2));
    checkOutput("err_opcode", 64'(err_opcode), 64'(m_err));
    if (q.size() > 0) begin
      checkOutput("out_opcode", 64'(out_opcode), 64'(q[0].opc));
      checkOutput("out_rd", 64'(out_rd), 64'(q[0].rd));
      checkOutput("out_rs1", 64'(out_rs1), 64'(q[0].rs1));
      checkOutput("out_rs2", 64'(out_rs2), 64'(q[0].rs2));
      checkOutput("out_imm", 64'(out_imm), 64'(q[0].imm));
      checkOutput("out_class", 64'(out_class), 64'(q[0].cls));
      checkOutput("out_is_imm", 64'(out_is_imm), 64'(q[0].is_imm));
      checkOutput("out_writes_rd", 64'(out_writes_rd), 64'(q[0].wr_rd));
    end
`ifdef DECODE_PERF_CNT_EN
    checkOutput("perf_decoded", 64'(perf_decoded), 64'(m_perf_dec));
    checkOutput("perf_stall", 64'(perf_stall), 64'(m_perf_stall));
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge
  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic ordy,
                               input logic fl, input logic res, input logic clr);
    logic acc;
    logic pop;
    exp_entry_t e;
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
    resume    = res;
    clear_err = clr;
    acc = v && m_in_ready;
    pop = (q.size() > 0) && ordy;
    last_accept = acc;
    if (acc) m_perf_dec++;
    if (v && !m_in_ready) m_perf_stall++;
    if (fl) begin
      q.delete();
      m_state = 0;
      m_err   = 8'h00;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e = expDecode(w);
        q.push_back(e);
        if (e.cls == 3'd7) begin
          m_state = 2;
          m_err   = e.opc;
        end else if (e.opc == 8'hF0) begin
          m_state = 1;
        end
      end else if (m_state == 1 && res) begin
        m_state = 0;
      end else if (m_state == 2 && clr) begin
        m_state = 0;
        m_err   = 8'h00;
      end
    end
    m_in_ready = (q.size() <= 1) && (m_state == 0);
    @(negedge clk);
    checkModel();
  endtask

  task automatic resetModel();
    q.delete();
    m_state      = 0;
    m_err        = 8'h00;
    m_in_ready   = 1'b1;
    m_perf_dec   = 0;
    m_perf_stall = 0;
  endtask

  task automatic idleInputs();
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    out_ready = 1'b0;
    flush     = 1'b0;
    resume    = 1'b0;
    clear_err = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int tries;
    vectors     = 0;
    miscompares = 0;
    last_accept = 1'b0;
    resetModel();
    idleInputs();
    rst_n = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_halted", 64'(halted), 64'd0);
    checkOutput("rst_error", 64'(error), 64'd0);
    checkOutput("rst_err_opcode", 64'(err_opcode), 64'd0);
    checkOutput("rst_out_opcode", 64'(out_opcode), 64'd0);
    checkOutput("rst_out_class", 64'(out_class), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Four classes streamed back to back
    applyStimulus(1, 32'h01000000, 1, 0, 0, 0);
    checkOutput("stream_cls0", 64'(out_class), 64'd0);
    checkOutput("stream_rdy0", 64'(in_ready), 64'd1);
    applyStimulus(1, 32'hA0000000, 1, 0, 0, 0);
    checkOutput("stream_cls1", 64'(out_class), 64'd1);
    applyStimulus(1, 32'hC0000000, 1, 0, 0, 0);
    checkOutput("stream_cls2", 64'(out_class), 64'd2);
    applyStimulus(1, 32'hE0000000, 1, 0, 0, 0);
    checkOutput("stream_cls3", 64'(out_class), 64'd3);
    checkOutput("stream_rdy3", 64'(in_ready), 64'd1);

    // Immediate form with negative immediate
    applyStimulus(1, 32'h100001FF, 1, 0, 0, 0);
    checkOutput("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    checkOutput("addi_is_imm", 64'(out_is_imm), 64'd1);
    checkOutput("addi_wr_rd", 64'(out_writes_rd), 64'd1);
    applyStimulus(0, 32'h0, 1, 0, 0, 0);

    // Backpressure: two words buffered, third held off, then all drain in order
    applyStimulus(1, 32'h01111111, 0, 0, 0, 0);
    applyStimulus(1, 32'h20222222, 0, 0, 0, 0);
    applyStimulus(1, 32'h30333333, 0, 0, 0, 0);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    tries = 0;
    do begin
      applyStimulus(1, 32'h30333333, 1, 0, 0, 0);
      tries++;
    end while (!last_accept && tries < 5);
    checkOutput("bp_third_accepted", 64'(last_accept), 64'd1);
    applyStimulus(0, 32'h0, 1, 0, 0, 0);
    applyStimulus(0, 32'h0, 1, 0, 0, 0);

    // Illegal opcode trap and clear
    applyStimulus(1, 32'h07000000, 1, 0, 0, 0);
    checkOutput("ill_class", 64'(out_class), 64'd7);
    checkOutput("ill_error", 64'(error), 64'd1);
    checkOutput("ill_err_opc", 64'(err_opcode), 64'h07);
    checkOutput("ill_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(0, 32'h0, 1, 0, 1, 0);
    checkOutput("ill_resume_ignored", 64'(error), 64'd1);
    applyStimulus(0, 32'h0, 1, 0, 0, 1);
    checkOutput("clr_in_ready", 64'(in_ready), 64'd1);
    checkOutput("clr_error", 64'(error), 64'd0);

    // HALT, resume, then HALT cancelled by a same-cycle flush
    applyStimulus(1, 32'hF0000000, 1, 0, 0, 0);
    checkOutput("halt_class", 64'(out_class), 64'd4);
    checkOutput("halt_halted", 64'(halted), 64'd1);
    checkOutput("halt_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(0, 32'h0, 1, 0, 0, 1);
    checkOutput("halt_clr_ignored", 64'(halted), 64'd1);
    applyStimulus(0, 32'h0, 1, 0, 1, 0);
    checkOutput("resume_halted", 64'(halted), 64'd0);
    checkOutput("resume_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1, 32'hF0000000, 1, 1, 0, 0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_halted", 64'(halted), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      w = {8'($urandom_range(0, 255)), 24'($urandom)};
      applyStimulus(1'($urandom_range(0, 9) < 7), w, 1'($urandom_range(0, 9) < 6),
                    1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0));
    end

    // Async reset with data in flight
    applyStimulus(1, 32'h40000001, 0, 0, 0, 0);
    applyStimulus(1, 32'h41000002, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("arst_halted", 64'(halted), 64'd0);
    checkOutput("arst_error", 64'(error), 64'd0);
    resetModel();
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkModel();

    for (int i = 0; i < 200; i++) begin
      w = {8'($urandom_range(0, 255)), 24'($urandom)};
      applyStimulus(1'($urandom_range(0, 9) < 7), w, 1'($urandom_range(0, 9) < 6),
                    1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
